// File: rtl/spi_sram_pkg.sv
// Shared opcodes, FSM states and address-advance helper for the SPI SRAM target.
package spi_sram_pkg;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_PAGE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        STAT_RD,
        STAT_WR,
        IGNORE
    } state_t;

    // Next address for the given mode; encoding 2'b11 behaves like sequential.
    function automatic logic [15:0] addr_advance(input logic [15:0] a,
                                                 input logic [1:0]  m,
                                                 input int          mem_l2b,
                                                 input int          page_l2b);
        logic [15:0] mem_mask;
        logic [15:0] pg_mask;
        logic [15:0] inc;
        mem_mask = 16'((32'd1 << mem_l2b) - 32'd1);
        pg_mask  = 16'((32'd1 << page_l2b) - 32'd1);
        inc      = a + 16'd1;
        case (m)
            MODE_BYTE:       return a;
            MODE_SEQ, 2'b11: return inc & mem_mask;
            default:         return (a & ~pg_mask) | (inc & pg_mask);
        endcase
    endfunction

endpackage

// File: rtl/spi_sram_target_sync.sv
// 2-FF synchronizer with edge detect built from registered stages only.
// Level is valid 2 clk after the pin; rise/fall flag the cycle the synced level changes.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign lvl  = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 slave backed by a byte array (23LC512-style READ/WRITE/RDSR/WRSR).
// All SPI pins are oversampled in clk; actions land 3 clk after the pin edge.
module spi_sram_target
    import spi_sram_pkg::*;
#(
    parameter int unsigned MEM_L2B  = 10,
    parameter int unsigned PAGE_L2B = 5,
    parameter logic [7:0]  MODE_RST = 8'h40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy,
    output logic cmd_err
);

    logic sck_rise, sck_fall, sck_lvl_unused;
    logic cs_n_s, cs_rise_unused, cs_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .din(spi_clk),
        .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .lvl(cs_n_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .lvl(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t      state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  sin_q, sin_d;
    logic [7:0]  sout_q, sout_d;
    logic [7:0]  mode_q, mode_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        cmd_err_q, cmd_err_d;
    logic        done_q, done_d;
    logic        abyte_q, abyte_d;

    logic [7:0]         mem_q [0:(1 << MEM_L2B) - 1];
    logic               mem_we;
    logic [MEM_L2B-1:0] mem_wa;
    logic [7:0]         mem_wd;

    logic [7:0]  sin_nxt;
    logic [15:0] addr_sh;
    logic [15:0] addr_nxt;
    logic        byte_mode;

    assign sin_nxt   = {sin_q[6:0], mosi_s};
    assign addr_sh   = {addr_q[14:0], mosi_s};
    assign addr_nxt  = addr_advance(addr_q, mode_q[7:6], MEM_L2B, PAGE_L2B);
    assign byte_mode = (mode_q[7:6] == MODE_BYTE);

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        addr_d    = addr_q;
        sin_d     = sin_q;
        sout_d    = sout_q;
        mode_d    = mode_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        done_d    = done_q;
        abyte_d   = abyte_q;
        cmd_err_d = 1'b0;
        busy_d    = ~cs_n_s;
        mem_we    = 1'b0;
        mem_wa    = addr_q[MEM_L2B-1:0];
        mem_wd    = sin_nxt;

        // Deselect beats any SCK edge seen in the same cycle.
        if (cs_n_s) begin
            state_d = IDLE;
            bcnt_d  = 3'd0;
            done_d  = 1'b0;
            abyte_d = 1'b0;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, CMD: begin
                    state_d = CMD;
                    if (sck_rise) begin
                        sin_d  = sin_nxt;
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            case (sin_nxt)
                                OP_READ, OP_WRITE: state_d = ADDR;
                                OP_RDSR: begin
                                    state_d = STAT_RD;
                                    sout_d  = mode_q;
                                end
                                OP_WRSR: state_d = STAT_WR;
                                default: begin
                                    state_d   = IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_sh;
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            abyte_d = ~abyte_q;
                            if (abyte_q) begin
                                state_d = (sin_q == OP_READ) ? RD : WR;
                                sout_d  = mem_q[addr_sh[MEM_L2B-1:0]];
                            end
                        end
                    end
                end
                RD, STAT_RD: begin
                    if (sck_fall) begin
                        miso_d = done_q ? 1'b0 : sout_q[7];
                        oe_d   = ~done_q;
                        sout_d = {sout_q[6:0], 1'b0};
                        bcnt_d = bcnt_q + 3'd1;
                        // The 8th fall emits the last bit and preloads the next byte.
                        if (bcnt_q == 3'd7) begin
                            if (state_q == STAT_RD) begin
                                sout_d = mode_q;
                            end else if (byte_mode) begin
                                done_d = 1'b1;
                            end else begin
                                addr_d = addr_nxt;
                                sout_d = mem_q[addr_nxt[MEM_L2B-1:0]];
                            end
                        end
                    end
                end
                WR: begin
                    if (sck_rise) begin
                        sin_d  = sin_nxt;
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7 && !done_q) begin
                            mem_we = 1'b1;
                            if (byte_mode) begin
                                done_d = 1'b1;
                            end else begin
                                addr_d = addr_nxt;
                            end
                        end
                    end
                end
                STAT_WR: begin
                    if (sck_rise) begin
                        sin_d  = sin_nxt;
                        bcnt_d = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7 && !done_q) begin
                            mode_d = sin_nxt;
                            done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IGNORE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcnt_q    <= 3'd0;
            addr_q    <= 16'd0;
            sin_q     <= 8'd0;
            sout_q    <= 8'd0;
            mode_q    <= MODE_RST;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            done_q    <= 1'b0;
            abyte_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            addr_q    <= addr_d;
            sin_q     <= sin_d;
            sout_q    <= sout_d;
            mode_q    <= mode_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            cmd_err_q <= cmd_err_d;
            done_q    <= done_d;
            abyte_q   <= abyte_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign busy        = busy_q;
    assign cmd_err     = cmd_err_q;

endmodule
